read_streamer: RTL
==================

READ_STREAMER -- requirements
Module: read_streamer

Interface
REQ-001 Parameter WIDTH, default 8: data word width, matching the RAM data port.
REQ-002 Parameter DEPTH, default 64: RAM word count.
REQ-003 Parameter ADDRESS, default 6: RAM address width; DEPTH == 2**ADDRESS.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1: reset, asynchronous and active-low.
REQ-006 start  input  1: one-cycle command strobe; sampled only in IDLE.
REQ-007 base_addr  input  ADDRESS: first RAM address of the burst; captured on the accepted start.
REQ-008 length  input  ADDRESS+1: word count, 0..DEPTH; captured on the accepted start.
REQ-009 ram_addr  output  ADDRESS: read address driven to the RAM port.
REQ-010 ram_wr_en  output  1: RAM write enable; constant 0.
REQ-011 ram_data_out  input  WIDTH: RAM read data, valid one clk after ram_addr is presented.
REQ-012 m_data  output  WIDTH: stream data.
REQ-013 m_valid  output  1: stream data valid.
REQ-014 m_ready  input  1: downstream accept; a transfer occurs when m_valid and m_ready are both 1.
REQ-015 busy  output  1: high from accepted start until the burst completes.
REQ-016 done  output  1: one-cycle pulse on the clock after the last word transfers.

Function
REQ-017 FSM states: IDLE, READ, DRAIN.
- IDLE -> READ on start with length != 0.
- READ -> DRAIN when the last read is issued.
- DRAIN -> IDLE when the last word transfers.
REQ-018 When start arrives with length == 0, the block stays in IDLE, busy stays 0, and done pulses on the next cycle.
REQ-019 start is ignored when busy == 1.
REQ-020 Read k (k = 0..length-1) uses ram_addr = (base_addr + k) mod DEPTH; addresses wrap from DEPTH-1 to 0 with no error.
REQ-021 A 2-entry output FIFO absorbs read latency; a read issues only when occupancy plus in-flight reads < 2.
REQ-022 With m_ready held at 1, throughput is one word per clk. The first m_valid appears 2 clks after start is accepted.
REQ-023 Stream data order equals address order; no word is dropped or duplicated under any m_ready pattern.
REQ-024 m_data and m_valid are held stable while m_valid == 1 and m_ready == 0.
REQ-025 ram_addr holds its last value when no read is issued.
REQ-026 In IDLE, m_valid = 0, and m_ready is a don't-care.

Reset
REQ-027 Asserting rst_n low at any time, including mid-burst, forces the following values: state IDLE, busy 0, done 0, m_valid 0, m_data 0, ram_addr 0, FIFO empty, in-flight count 0.
REQ-028 After release, no stale word is presented; the block waits for a new start.

Configuration
REQ-029 Macro READ_STREAMER_LAST_EN:
- Defined: adds output m_last (1 bit), which is 1 alongside the final word of each burst and 0 otherwise; reset value 0.
- Undefined: the port is absent, and behaviour is otherwise identical.

Structure
REQ-030 The WIDTH, DEPTH and ADDRESS defaults and the FSM state encoding belong in the shared RAM package.
REQ-031 The output FIFO is a sub-module, stream_fifo2 (2-entry, WIDTH-wide, first-word-fall-through).

Verification
REQ-032 Memory preloaded with ram[i]=i; start, base_addr=4, length=5, m_ready=1 -> m_data 4,5,6,7,8 on consecutive cycles, then done pulses and busy falls.
REQ-033 Wrap case, base_addr=62, length=4 -> m_data 62,63,0,1.
REQ-034 Backpressure case, length=6, m_ready toggling 1,0,0,1,... -> sequence intact and m_data stable while stalled.
REQ-035 length=0 -> no m_valid, busy stays 0, and done pulses once.
REQ-036 rst_n pulsed low after 2 of 8 words -> outputs reach their reset values asynchronously; a new start with base_addr=0, length=2 streams 0,1.
REQ-037 start during busy -> ignored, and the original burst completes unaltered.

Source files
------------

// File: rtl/read_streamer_pkg.sv
// Shared RAM package for the read streamer.
// Holds the RAM geometry defaults (data width, word count, address width),
// the streamer FSM state encoding and a small occupancy helper.
package read_streamer_pkg;

    localparam int RAM_WIDTH   = 8;
    localparam int RAM_DEPTH   = 64;
    localparam int RAM_ADDRESS = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rs_state_e;

    // Words that will still be held after this clock edge: the FIFO contents
    // plus the read whose data is on the RAM port, minus the word leaving now.
    function automatic logic [1:0] fill_level(input logic [1:0] occ,
                                              input logic       inflight,
                                              input logic       pop);
        return occ + {1'b0, inflight} - {1'b0, pop};
    endfunction

endpackage

// File: rtl/read_streamer_stream_fifo2.sv
// stream_fifo2: 2-entry first-word-fall-through FIFO.
// The head entry drives the stream outputs directly from flops, so data and
// valid stay stable until the word is accepted.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_en/wr_data  push a word (caller guarantees space)
//   rd_ready       downstream accept; pops the head when it is valid
//   rd_data/rd_valid  head word and its valid flag
//   level          number of stored words (0..2)
module stream_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [1:0]       level
);

    logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic             head_v_q, head_v_d, tail_v_q, tail_v_d;
    logic [WIDTH-1:0] mid_head_s;
    logic             mid_head_v_s, mid_tail_v_s;
    logic             pop_s;

    assign pop_s    = head_v_q & rd_ready;
    assign rd_data  = head_q;
    assign rd_valid = head_v_q;
    assign level    = {1'b0, head_v_q} + {1'b0, tail_v_q};

    // Next entry contents: apply the pop first, then place the pushed word.
    always_comb begin
        mid_head_s   = head_q;
        mid_head_v_s = head_v_q;
        mid_tail_v_s = tail_v_q;
        if (pop_s) begin
            if (tail_v_q) begin
                mid_head_s   = tail_q;
                mid_tail_v_s = 1'b0;
            end else begin
                mid_head_v_s = 1'b0;
            end
        end else begin
            mid_head_v_s = head_v_q;
        end

        head_d   = mid_head_s;
        head_v_d = mid_head_v_s;
        tail_d   = tail_q;
        tail_v_d = mid_tail_v_s;
        if (wr_en) begin
            if (!mid_head_v_s) begin
                head_d   = wr_data;
                head_v_d = 1'b1;
            end else begin
                tail_d   = wr_data;
                tail_v_d = 1'b1;
            end
        end else begin
            tail_d = tail_q;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= {WIDTH{1'b0}};
            tail_q   <= {WIDTH{1'b0}};
            head_v_q <= 1'b0;
            tail_v_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            head_v_q <= head_v_d;
            tail_v_q <= tail_v_d;
        end
    end

endmodule

// File: rtl/read_streamer.sv
// read_streamer: reads a burst of consecutive RAM words (wrapping at the end
// of the RAM) and presents them on a valid/ready stream.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start, base_addr, length burst command, taken only while idle
//   ram_addr, ram_wr_en      RAM port (read only, 1-cycle read latency)
//   ram_data_out             RAM read data
//   m_data, m_valid, m_ready output stream
//   m_last                   final word of the burst (READ_STREAMER_LAST_EN)
//   busy, done               burst in progress / 1-cycle completion pulse
// Optional feature macro: READ_STREAMER_LAST_EN adds the m_last output.
module read_streamer
    import read_streamer_pkg::*;
#(
    parameter int WIDTH   = RAM_WIDTH,
    parameter int DEPTH   = RAM_DEPTH,
    parameter int ADDRESS = RAM_ADDRESS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDRESS-1:0] base_addr,
    input  logic [ADDRESS:0]   length,
    output logic [ADDRESS-1:0] ram_addr,
    output logic               ram_wr_en,
    input  logic [WIDTH-1:0]   ram_data_out,
    output logic [WIDTH-1:0]   m_data,
    output logic               m_valid,
    input  logic               m_ready,
`ifdef READ_STREAMER_LAST_EN
    output logic               m_last,
`endif
    output logic               busy,
    output logic               done
);

    localparam logic [ADDRESS-1:0] ADDR_ONE  = ADDRESS'(1'b1);
    localparam logic [ADDRESS-1:0] ADDR_LAST = ADDRESS'(DEPTH - 1);
    localparam logic [ADDRESS:0]   LEN_ONE   = (ADDRESS + 1)'(1'b1);
    localparam logic [ADDRESS:0]   LEN_ZERO  = (ADDRESS + 1)'(1'b0);

    rs_state_e          state_q, state_d;
    logic [ADDRESS-1:0] ram_addr_q, ram_addr_d;
    logic [ADDRESS:0]   rd_left_q, rd_left_d;   // reads still to issue
    logic [ADDRESS:0]   wr_left_q, wr_left_d;   // words still to transfer
    logic               inflight_q, inflight_d; // read data on ram_data_out now
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               issue_s;
    logic               pop_s;
    logic [1:0]         fifo_level_s;

    assign ram_addr  = ram_addr_q;
    assign ram_wr_en = 1'b0;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pop_s     = m_valid & m_ready;

`ifdef READ_STREAMER_LAST_EN
    assign m_last = m_valid & (wr_left_q == LEN_ONE);
`endif

    // The read issued in a cycle is the address the RAM samples at its end;
    // its data is pushed into the FIFO one clock later.
    stream_fifo2 #(.WIDTH(WIDTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (inflight_q),
        .wr_data  (ram_data_out),
        .rd_ready (m_ready),
        .rd_data  (m_data),
        .rd_valid (m_valid),
        .level    (fifo_level_s)
    );

    // Next-state, read issue and burst bookkeeping.
    always_comb begin
        state_d    = state_q;
        ram_addr_d = ram_addr_q;
        rd_left_d  = rd_left_q;
        wr_left_d  = wr_left_q;
        done_d     = 1'b0;
        issue_s    = 1'b0;

        // Counting the departing word keeps one word per clock with only two
        // entries of buffering.
        if ((state_q == ST_READ) &&
            (fill_level(fifo_level_s, inflight_q, pop_s) < 2'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end

        if (pop_s) begin
            wr_left_d = wr_left_q - LEN_ONE;
        end else begin
            wr_left_d = wr_left_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length != LEN_ZERO) begin
                        state_d    = ST_READ;
                        ram_addr_d = base_addr;
                        rd_left_d  = length;
                        wr_left_d  = length;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (issue_s) begin
                    rd_left_d = rd_left_q - LEN_ONE;
                    // After the final read the address is left where it is.
                    if (rd_left_q == LEN_ONE) begin
                        state_d = ST_DRAIN;
                    end else if (ram_addr_q == ADDR_LAST) begin
                        ram_addr_d = {ADDRESS{1'b0}};
                    end else begin
                        ram_addr_d = ram_addr_q + ADDR_ONE;
                    end
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (pop_s && (wr_left_q == LEN_ONE)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        inflight_d = issue_s;
        busy_d     = (state_d != ST_IDLE);
    end

    // State and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ram_addr_q <= {ADDRESS{1'b0}};
            rd_left_q  <= LEN_ZERO;
            wr_left_q  <= LEN_ZERO;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ram_addr_q <= ram_addr_d;
            rd_left_q  <= rd_left_d;
            wr_left_q  <= wr_left_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

endmodule
